// File: rtl/typer_pkg.sv
// Shared constants and plot-FSM encoding for the typed-sequence builder.
package typer_pkg;

  localparam int MAX_CHARS = 12;
  localparam int SEQ_W     = 8 * MAX_CHARS;
  localparam int CNT_W     = 4;

  localparam logic [7:0] ASCII_BKSP  = 8'h08;
  localparam logic [7:0] ASCII_ENTER = 8'h0D;
  localparam logic [7:0] ASCII_MIN   = 8'h20;
  localparam logic [7:0] ASCII_MAX   = 8'h7E;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR_REQ  = 3'd1,
    CLR_WAIT = 3'd2,
    DRW_REQ  = 3'd3,
    DRW_WAIT = 3'd4
  } plot_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_MIN) && (c <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/typed_sequence_builder_if.sv
// Plot-sequence handshake between the line builder (master) and the drawer (slave).
interface typed_sequence_builder_if;
  import typer_pkg::*;

  logic             ready_to_plot_sequence;
  logic             plot_sequence;
  logic [SEQ_W-1:0] sequence_;
  logic [7:0]       num_char;
  logic [8:0]       x_start;
  logic [8:0]       y_start;
  logic             enable_clear;

  modport master (
    input  ready_to_plot_sequence,
    output plot_sequence, sequence_, num_char, x_start, y_start, enable_clear
  );

  modport slave (
    output ready_to_plot_sequence,
    input  plot_sequence, sequence_, num_char, x_start, y_start, enable_clear
  );

endinterface

// File: rtl/typed_char_buffer.sv
// Keystroke decode and packed line buffer: insert, backspace, enter/submit, reject.
module typed_char_buffer
  import typer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [7:0]       key_code,
  input  logic             clr_dirty,
  output logic [SEQ_W-1:0] line,
  output logic [CNT_W-1:0] count,
  output logic             dirty,
  output logic             submit_valid,
  output logic [SEQ_W-1:0] submit_seq,
  output logic [CNT_W-1:0] submit_len,
  output logic             key_rejected
);

  logic [SEQ_W-1:0] line_nx;
  logic [CNT_W-1:0] count_nx;
  logic             set_dirty;
  logic             rej_nx;
  logic             sub_nx;

  always_comb begin
    line_nx   = line;
    count_nx  = count;
    set_dirty = 1'b0;
    rej_nx    = 1'b0;
    sub_nx    = 1'b0;
    if (key_valid) begin
      if (is_printable(key_code)) begin
        if (count < CNT_W'(MAX_CHARS)) begin
          // char i lives at the top of the word, char0 in the MS byte
          for (int i = 0; i < MAX_CHARS; i++)
            if (i == int'(count)) line_nx[SEQ_W-8-8*i +: 8] = key_code;
          count_nx  = count + 1'b1;
          set_dirty = 1'b1;
        end else begin
          rej_nx = 1'b1;
        end
      end else if (key_code == ASCII_BKSP) begin
        if (count != '0) begin
          for (int i = 0; i < MAX_CHARS; i++)
            if (i == int'(count) - 1) line_nx[SEQ_W-8-8*i +: 8] = 8'h00;
          count_nx  = count - 1'b1;
          set_dirty = 1'b1;
        end else begin
          rej_nx = 1'b1;
        end
      end else if (key_code == ASCII_ENTER) begin
        sub_nx    = 1'b1;
        line_nx   = '0;
        count_nx  = '0;
        set_dirty = 1'b1;
      end else begin
        rej_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line         <= '0;
      count        <= '0;
      dirty        <= 1'b0;
      submit_valid <= 1'b0;
      submit_seq   <= '0;
      submit_len   <= '0;
      key_rejected <= 1'b0;
    end else begin
      line         <= line_nx;
      count        <= count_nx;
      // a fresh edit wins over the snapshot clearing the flag
      dirty        <= set_dirty | (dirty & ~clr_dirty);
      submit_valid <= sub_nx;
      key_rejected <= rej_nx;
      if (sub_nx) begin
        submit_seq <= line;
        submit_len <= count;
      end
    end
  end

endmodule

// File: rtl/typed_sequence_builder.sv
// Line builder top: erase-then-redraw plot FSM driving the sequence drawer.
module typed_sequence_builder
  import typer_pkg::*;
#(
  parameter logic [8:0] X_ORIGIN   = 9'd16,
  parameter logic [8:0] Y_ORIGIN   = 9'd200,
  parameter int         PLOT_GUARD = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_valid,
  input  logic [7:0]                key_code,
  typed_sequence_builder_if.master  plot,
  output logic                      submit_valid,
  output logic [SEQ_W-1:0]          submit_seq,
  output logic [CNT_W-1:0]          submit_len,
  output logic                      key_rejected
);

  localparam int GW = (PLOT_GUARD < 1) ? 1 : $clog2(PLOT_GUARD + 1);

  plot_state_t      state, state_nx;
  logic [GW-1:0]    guard;
  logic             snap_taken;
  logic [SEQ_W-1:0] drawn_seq;
  logic [CNT_W-1:0] drawn_cnt;

  logic [SEQ_W-1:0] line;
  logic [CNT_W-1:0] count;
  logic             dirty;

  logic issue, issue_clear, issue_live, take_snap, load_guard;

  typed_char_buffer u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .clr_dirty    (take_snap),
    .line         (line),
    .count        (count),
    .dirty        (dirty),
    .submit_valid (submit_valid),
    .submit_seq   (submit_seq),
    .submit_len   (submit_len),
    .key_rejected (key_rejected)
  );

  assign plot.x_start = X_ORIGIN;
  assign plot.y_start = Y_ORIGIN;

  always_comb begin
    state_nx    = state;
    issue       = 1'b0;
    issue_clear = 1'b0;
    issue_live  = 1'b0;
    take_snap   = 1'b0;
    load_guard  = 1'b0;
    case (state)
      IDLE: if (dirty) state_nx = CLR_REQ;
      CLR_REQ: begin
        // nothing on screen yet: never hand the drawer an empty erase
        if (drawn_cnt == '0) begin
          state_nx = DRW_REQ;
        end else if (plot.ready_to_plot_sequence) begin
          issue       = 1'b1;
          issue_clear = 1'b1;
          load_guard  = 1'b1;
          state_nx    = CLR_WAIT;
        end
      end
      CLR_WAIT: if (guard == '0 && plot.ready_to_plot_sequence) state_nx = DRW_REQ;
      DRW_REQ: begin
        if (!snap_taken) begin
          take_snap = 1'b1;
          if (count == '0) begin
            state_nx = IDLE;
          end else if (plot.ready_to_plot_sequence) begin
            issue      = 1'b1;
            issue_live = 1'b1;
            load_guard = 1'b1;
            state_nx   = DRW_WAIT;
          end
        end else if (plot.ready_to_plot_sequence) begin
          issue      = 1'b1;
          load_guard = 1'b1;
          state_nx   = DRW_WAIT;
        end
      end
      DRW_WAIT: if (guard == '0 && plot.ready_to_plot_sequence) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      guard             <= '0;
      snap_taken        <= 1'b0;
      drawn_seq         <= '0;
      drawn_cnt         <= '0;
      plot.plot_sequence <= 1'b0;
      plot.sequence_    <= '0;
      plot.num_char     <= '0;
      plot.enable_clear <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_guard)      guard <= GW'(PLOT_GUARD);
      else if (guard != '0) guard <= guard - 1'b1;
      snap_taken <= (state_nx == DRW_REQ) ? (snap_taken | take_snap) : 1'b0;
      if (take_snap) begin
        drawn_seq <= line;
        drawn_cnt <= count;
      end
      plot.plot_sequence <= issue;
      if (issue) begin
        // in the snapshot cycle the live buffer is the snapshot being taken
        plot.sequence_    <= issue_live ? line : drawn_seq;
        plot.num_char     <= {{(8-CNT_W){1'b0}}, (issue_live ? count : drawn_cnt)};
        plot.enable_clear <= issue_clear;
      end
    end
  end

endmodule

// File: tb/tb_typed_sequence_builder.sv
// Directed bench for typed_sequence_builder with a simple busy-drawer responder.
module tb_typed_sequence_builder;
  import typer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        submit_valid;
  logic [95:0] submit_seq;
  logic [3:0]  submit_len;
  logic        key_rejected;

  typed_sequence_builder_if pif();

  typed_sequence_builder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .plot         (pif),
    .submit_valid (submit_valid),
    .submit_seq   (submit_seq),
    .submit_len   (submit_len),
    .key_rejected (key_rejected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [95:0] seq;
    logic [7:0]  num;
  } plot_ev_t;

  plot_ev_t evq[$];
  int checks = 0;
  int failures = 0;
  int busy = 0;
  int bad_plots = 0;
  logic force_low = 1'b0;

  // Drawer: goes busy for 3 cycles after each request, optionally held off.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0;
    end else if (pif.plot_sequence) begin
      evq.push_back('{pif.enable_clear, pif.sequence_, pif.num_char});
      if (!pif.ready_to_plot_sequence || pif.num_char == 8'd0) bad_plots++;
      busy = 3;
    end else if (busy > 0) begin
      busy--;
    end
    pif.ready_to_plot_sequence = (busy == 0) && !force_low;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [7:0] c, output logic rej, output logic sub);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk); #1;
    key_valid = 1'b0;
    rej = key_rejected;
    sub = submit_valid;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_events(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (evq.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq(tag, 128'(evq.size() >= n), 128'd1);
  endtask

  logic rej, sub;
  int   rej_total;
  logic [95:0] exp_seq;

  initial begin
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = 8'h00;
    pif.ready_to_plot_sequence = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_plot", pif.plot_sequence, 0);
    check_eq("rst_seq", pif.sequence_, 0);
    check_eq("rst_num", pif.num_char, 0);
    check_eq("rst_clr", pif.enable_clear, 0);
    check_eq("rst_sub", {submit_valid, submit_len, submit_seq}, 0);
    check_eq("rst_rej", key_rejected, 0);
    check_eq("x_start", pif.x_start, 9'd16);
    check_eq("y_start", pif.y_start, 9'd200);
    rst_n = 1'b1;
    idle(2);

    // 'A','B': single draw, no erase
    evq.delete();
    press(8'h41, rej, sub);
    check_eq("A_rej", rej, 0);
    press(8'h42, rej, sub);
    idle(40);
    check_eq("AB_events", evq.size(), 1);
    check_eq("AB_draw_clr", evq[0].clr, 0);
    check_eq("AB_draw_seq", evq[0].seq, {16'h4142, 80'h0});
    check_eq("AB_draw_num", evq[0].num, 2);

    // backspace: erase "AB" then draw "A"
    evq.delete();
    press(ASCII_BKSP, rej, sub);
    check_eq("bs_rej", rej, 0);
    idle(40);
    check_eq("bs_events", evq.size(), 2);
    check_eq("bs_clr0", {evq[0].clr, evq[0].num}, {1'b1, 8'd2});
    check_eq("bs_seq0", evq[0].seq, {16'h4142, 80'h0});
    check_eq("bs_clr1", {evq[1].clr, evq[1].num}, {1'b0, 8'd1});
    check_eq("bs_seq1", evq[1].seq, {8'h41, 88'h0});

    // empty the line, then backspace on empty and an unknown code are rejected
    press(ASCII_BKSP, rej, sub);
    idle(40);
    press(ASCII_BKSP, rej, sub);
    check_eq("bs_empty_rej", rej, 1);
    press(8'h07, rej, sub);
    check_eq("bad_code_rej", rej, 1);

    // 13 printable keys: only 12 fit
    evq.delete();
    rej_total = 0;
    for (int i = 0; i < 13; i++) begin
      press(8'h61 + 8'(i), rej, sub);
      rej_total += int'(rej);
    end
    check_eq("full_last_rej", rej, 1);
    check_eq("full_rej_total", rej_total, 1);
    idle(100);
    check_eq("full_last_clr", evq[evq.size()-1].clr, 0);
    check_eq("full_last_num", evq[evq.size()-1].num, 12);
    check_eq("full_last_seq", evq[evq.size()-1].seq, 96'h6162636465666768696A6B6C);
    press(8'h7A, rej, sub);
    check_eq("full_again_rej", rej, 1);

    // enter on the full line
    press(ASCII_ENTER, rej, sub);
    check_eq("sub12_valid", sub, 1);
    check_eq("sub12_len", submit_len, 12);
    check_eq("sub12_seq", submit_seq, 96'h6162636465666768696A6B6C);
    idle(40);

    // 'H','I', enter: submit, erase only
    press(8'h48, rej, sub);
    press(8'h49, rej, sub);
    idle(40);
    evq.delete();
    press(ASCII_ENTER, rej, sub);
    check_eq("subHI_valid", sub, 1);
    check_eq("subHI_seq", submit_seq, {16'h4849, 80'h0});
    check_eq("subHI_len", submit_len, 2);
    idle(1);
    check_eq("subHI_pulse", submit_valid, 0);
    check_eq("subHI_hold", submit_len, 2);
    idle(40);
    check_eq("enter_events", evq.size(), 1);
    check_eq("enter_clr", {evq[0].clr, evq[0].num}, {1'b1, 8'd2});
    check_eq("enter_seq", evq[0].seq, {16'h4849, 80'h0});

    // edits while the drawer is held busy during DRW_WAIT
    evq.delete();
    press(8'h58, rej, sub);
    wait_events("X_draw_wait", 1, 40);
    force_low = 1'b1;
    press(8'h59, rej, sub);
    press(8'h5A, rej, sub);
    idle(50);
    check_eq("held_events", evq.size(), 1);
    force_low = 1'b0;
    idle(60);
    check_eq("held_after", evq.size(), 3);
    check_eq("held_clr", {evq[1].clr, evq[1].num}, {1'b1, 8'd1});
    check_eq("held_clr_seq", evq[1].seq, {8'h58, 88'h0});
    check_eq("held_drw", {evq[2].clr, evq[2].num}, {1'b0, 8'd3});
    check_eq("held_drw_seq", evq[2].seq, {24'h58595A, 72'h0});

    // reset in CLR_WAIT
    evq.delete();
    press(ASCII_BKSP, rej, sub);
    wait_events("clr_for_rst", 1, 40);
    check_eq("pre_rst_state", dut.state, CLR_WAIT);
    rst_n = 1'b0;
    idle(1);
    check_eq("mid_rst_plot", pif.plot_sequence, 0);
    check_eq("mid_rst_seq", pif.sequence_, 0);
    check_eq("mid_rst_num", {pif.num_char, pif.enable_clear}, 0);
    check_eq("mid_rst_sub", {submit_valid, submit_len, submit_seq}, 0);
    check_eq("mid_rst_state", dut.state, IDLE);
    rst_n = 1'b1;
    idle(2);
    evq.delete();
    press(8'h51, rej, sub);
    idle(40);
    check_eq("post_rst_events", evq.size(), 1);
    check_eq("post_rst_draw", {evq[0].clr, evq[0].num}, {1'b0, 8'd1});
    check_eq("post_rst_seq", evq[0].seq, {8'h51, 88'h0});

    check_eq("bad_plots", bad_plots, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
